// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_pkg
// Purpose : Shared types, constants and the address range helper used by the
//           data-memory store buffer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int WORD_BYTES = 4;
  // Wide enough for any word index carried by a 32-bit byte address.
  localparam int IDX_W = 30;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } sb_entry_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth_words);
    logic [33:0] limit;
    limit = 34'(depth_words) * 34'(WORD_BYTES);
    return ({2'b00, addr} < limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_store_buffer_store_fifo.sv
//------------------------------------------------------------------------------
// Module  : store_fifo
// Purpose : In-order circular store buffer with a parallel youngest-hit match.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_fifo
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PW = $clog2(SB_DEPTH),
  localparam int CW = $clog2(SB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic [31:0]      push_data,
  input  logic             pop,
  output sb_entry_t        head,
  output logic [CW-1:0]    count,
  output logic             full,
  input  logic [IDX_W-1:0] match_idx,
  output logic             match_hit,
  output logic [31:0]      match_data
);

  sb_entry_t     r_entries [SB_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_slot;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) r_entries[i] <= '0;
    end else begin
      if (pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PW'(1);
      end
      if (push) begin
        r_entries[r_tail] <= '{valid: 1'b1, idx: push_idx, data: push_data};
        r_tail            <= r_tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    w_slot     = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_slot = r_head + PW'(k);
      if (r_entries[w_slot].valid && (r_entries[w_slot].idx == match_idx)) begin
        match_hit  = 1'b1;
        match_data = r_entries[w_slot].data;
      end
    end
  end

  assign head  = r_entries[r_head];
  assign count = r_count;
  assign full  = (r_count == CW'(SB_DEPTH));

endmodule

`default_nettype wire

// File: rtl/dmem_store_buffer.sv
//------------------------------------------------------------------------------
// Module  : dmem_store_buffer
// Purpose : MEM-stage data memory: store buffer draining into a word RAM with
//           zero-latency loads. Define DMEM_FORWARD_EN for store-to-load
//           forwarding; otherwise loads hitting a pending store stall.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int SB_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          write_enab,
  input  logic                          read_enab,
  input  logic [31:0]                   data_addr,
  input  logic [31:0]                   write_data,
  output logic [31:0]                   read_data,
  output logic                          stall,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic                          addr_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_addr_fault;
  logic             w_bad;
  logic [AW-1:0]    w_idx;
  logic [IDX_W-1:0] w_key;
  logic             w_push;
  logic             w_drain;
  logic             w_stall;
  logic             w_full;
  logic             w_hit;
  logic [31:0]      w_fwd_data;
  sb_entry_t        w_head;
  logic             w_unused;

  assign w_bad = (data_addr[1:0] != 2'b00) || !addr_in_range(data_addr, DEPTH_WORDS);
  assign w_idx = data_addr[AW+1:2];
  assign w_key = IDX_W'(w_idx);

  store_fifo #(
    .SB_DEPTH (SB_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .n_reset    (n_reset),
    .push       (w_push),
    .push_idx   (w_key),
    .push_data  (write_data),
    .pop        (w_drain),
    .head       (w_head),
    .count      (sb_count),
    .full       (w_full),
    .match_idx  (w_key),
    .match_hit  (w_hit),
    .match_data (w_fwd_data)
  );

`ifdef DMEM_FORWARD_EN
  assign w_stall  = write_enab && !w_bad && w_full;
  assign w_unused = ^w_head.idx[IDX_W-1:AW];
`else
  assign w_stall  = (write_enab && !w_bad && w_full) ||
                    (read_enab && !w_bad && w_hit);
  assign w_unused = ^{w_head.idx[IDX_W-1:AW], w_fwd_data};
`endif

  assign w_push = write_enab && !w_bad && !w_full;
  // A serviced load owns the single RAM port; a stalled one does not.
  assign w_drain = w_head.valid && (!read_enab || w_stall);

  always_comb begin
    read_data = '0;
    if (read_enab && !w_bad) begin
`ifdef DMEM_FORWARD_EN
      read_data = w_hit ? w_fwd_data : r_mem[w_idx];
`else
      read_data = r_mem[w_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_drain) r_mem[w_head.idx[AW-1:0]] <= w_head.data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_addr_fault <= 1'b0;
    else if ((write_enab || read_enab) && w_bad) r_addr_fault <= 1'b1;
  end

  assign stall      = w_stall;
  assign addr_fault = r_addr_fault;

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
//------------------------------------------------------------------------------
// Module  : tb_dmem_store_buffer
// Purpose : Directed bench for dmem_store_buffer with a reference model and a
//           load-result scoreboard.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        write_enab;
  logic        read_enab;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic [2:0]  sb_count;
  logic        addr_fault;

  int checks   = 0;
  int failures = 0;

  bit [31:0]   m_ram [64];
  int          m_qidx [$];
  bit [31:0]   m_qdat [$];
  bit          m_fault;
  bit          m_last_stall;
  logic [31:0] exp_q [$];

  dmem_store_buffer #(.DEPTH_WORDS(64), .SB_DEPTH(4)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .write_enab (write_enab),
    .read_enab  (read_enab),
    .data_addr  (data_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .sb_count   (sb_count),
    .addr_fault (addr_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request cycle: drive, check combinational outputs, clock, update model.
  task automatic step(input bit we, input bit re, input logic [31:0] addr,
                      input logic [31:0] wd);
    bit        bad, hit, full, e_stall, push, drain;
    int        idx;
    bit [31:0] hv, e_rd;
    logic [31:0] e;
    write_enab = we;
    read_enab  = re;
    data_addr  = addr;
    write_data = wd;
    #2;
    bad  = (addr[1:0] != 2'b00) || (addr >= 32'd256);
    idx  = int'(addr[7:2]);
    hit  = 1'b0;
    hv   = '0;
    full = (m_qidx.size() == 4);
    foreach (m_qidx[i]) if (m_qidx[i] == idx) begin hit = 1'b1; hv = m_qdat[i]; end
`ifdef DMEM_FORWARD_EN
    e_stall = we && !bad && full;
    e_rd    = bad ? 32'd0 : (hit ? hv : m_ram[idx]);
`else
    e_stall = (we && !bad && full) || (re && !bad && hit);
    e_rd    = bad ? 32'd0 : m_ram[idx];
`endif
    push  = we && !bad && !full;
    drain = (m_qidx.size() > 0) && (!re || e_stall);
    m_last_stall = e_stall;
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    if (re && !e_stall) begin
      exp_q.push_back(e_rd);
      e = exp_q.pop_front();
      chk("read_data", read_data, e);
    end
    @(posedge clk);
    if ((we || re) && bad) m_fault = 1'b1;
    if (drain) begin
      m_ram[m_qidx[0]] = m_qdat[0];
      void'(m_qidx.pop_front());
      void'(m_qdat.pop_front());
    end
    if (push) begin
      m_qidx.push_back(idx);
      m_qdat.push_back(wd);
    end
    #1;
    chk("sb_count", {29'd0, sb_count}, 32'(m_qidx.size()));
    chk("addr_fault", {31'd0, addr_fault}, {31'd0, m_fault});
  endtask

  // Holds a load until it is serviced, with a bounded number of retries.
  task automatic load_hold(input logic [31:0] addr);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 8 && !done; t++) begin
      step(1'b0, 1'b1, addr, 32'd0);
      done = !m_last_stall;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL load_timeout observed=stalled expected=serviced addr=%0d", addr);
    end
  endtask

  initial begin
    n_reset    = 1'b0;
    write_enab = 1'b0;
    read_enab  = 1'b0;
    data_addr  = '0;
    write_data = '0;
    m_fault    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sb_count", {29'd0, sb_count}, 32'd0);
    chk("rst_addr_fault", {31'd0, addr_fault}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    n_reset = 1'b1;

    // Give every RAM word a known value.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 32'(i * 4), $urandom);
    step(1'b0, 1'b0, 32'd0, 32'd0);

    // Store then load the same word; the drained value is visible from RAM.
    step(1'b1, 1'b0, 32'd84, 32'd7);
    load_hold(32'd84);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    load_hold(32'd84);
    chk("ram21", read_data, 32'd7);

    // Back-to-back stores drain one per cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(80 + 4 * i), 32'(100 + i));
    step(1'b0, 1'b0, 32'd0, 32'd0);

    // Stores interleaved with loads to address 0, then a store to 100.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'(104 + 4 * i), 32'(200 + i));
      step(1'b0, 1'b1, 32'd0, 32'd0);
    end
    step(1'b1, 1'b0, 32'd100, 32'd300);
    load_hold(32'd100);

    // Two stores to one word: the later value wins.
    step(1'b1, 1'b0, 32'd80, 32'd1);
    step(1'b1, 1'b0, 32'd80, 32'd2);
    load_hold(32'd80);
    chk("same_word", read_data, 32'd2);

    // Out-of-range and misaligned accesses.
    step(1'b1, 1'b0, 32'd256, 32'hdead);
    step(1'b1, 1'b0, 32'd82, 32'hbeef);
    step(1'b0, 1'b1, 32'd258, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0);

    // Mixed random traffic over a handful of words.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        step(1'b1, 1'b0, 32'(4 * $urandom_range(23, 16)), $urandom);
      else
        load_hold(32'(4 * $urandom_range(23, 16)));
    end

    // Reset in the middle of a store burst.
    step(1'b1, 1'b0, 32'd40, 32'h11);
    step(1'b1, 1'b0, 32'd44, 32'h22);
    step(1'b1, 1'b0, 32'd48, 32'h33);
    write_enab = 1'b0;
    n_reset    = 1'b0;
    m_qidx.delete();
    m_qdat.delete();
    m_fault = 1'b0;
    #1;
    chk("midrst_sb_count", {29'd0, sb_count}, 32'd0);
    chk("midrst_addr_fault", {31'd0, addr_fault}, 32'd0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    load_hold(32'd40);
    load_hold(32'd44);
    load_hold(32'd48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
